// File: rtl/oct_rr_arbiter_pkg.sv
// ============================================================================
// oct_rr_arbiter_pkg : shared widths, state type and index helper for the
//                      eight-client round-robin arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package oct_rr_arbiter_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick8.sv
// ============================================================================
// rr_pick8 : combinational rotate-priority picker; first set request at or
//            after ptr, wrapping modulo 8.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick8
    import oct_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_any
);

    // Scan from the farthest offset back to ptr so the closest hit wins last.
    always_comb begin
        pick_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[ptr + IDX_W'(i)]) begin
                pick_idx = ptr + IDX_W'(i);
            end
        end
        pick_any = |req;
    end

endmodule

`default_nettype wire

// File: rtl/oct_rr_arbiter.sv
// ============================================================================
// oct_rr_arbiter : eight-requester round-robin arbiter with registered
//                  one-hot grant, binary index and optional hold timeout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module oct_rr_arbiter
    import oct_rr_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             revoked
);

    localparam logic [CNT_W-1:0] C_HOLD_LAST  = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
    localparam logic             C_TIMEOUT_EN = (HOLD_MAX != 0);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             revoked_q, revoked_d;

    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic             w_rel_drop;
    logic             w_rel_timeout;
    logic             w_release;

    rr_pick8 u_pick (
        .req      (req),
        .ptr      (ptr_q),
        .pick_idx (w_pick_idx),
        .pick_any (w_pick_any)
    );

    assign w_rel_drop    = ~req[gnt_idx_q];
    assign w_rel_timeout = C_TIMEOUT_EN && (cnt_q == C_HOLD_LAST);
    assign w_release     = done | w_rel_drop | w_rel_timeout;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        revoked_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_pick_any) begin
                    gnt_d       = idx_to_onehot(w_pick_idx);
                    gnt_idx_d   = w_pick_idx;
                    gnt_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (w_release) begin
                    // 3-bit add wraps 7 back to 0 for free.
                    ptr_d       = gnt_idx_q + IDX_W'(1);
                    gnt_d       = '0;
                    gnt_idx_d   = '0;
                    gnt_valid_d = 1'b0;
                    revoked_d   = w_rel_timeout & ~done & ~w_rel_drop;
                    state_d     = IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            revoked_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            revoked_q   <= revoked_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign revoked   = revoked_q;

endmodule

`default_nettype wire

// File: tb/tb_oct_rr_arbiter.sv
// ============================================================================
// tb_oct_rr_arbiter : self-checking bench for oct_rr_arbiter against a
//                     cycle-level behavioural model of the grant rules.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_oct_rr_arbiter;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       revoked;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: owner = client holding the grant (-1 when none), held = cycles
    // the grant has been visible so far, ptr = first client to consider.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_rev   = 1'b0;

    oct_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .revoked   (revoked)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] exp_vec();
        if (m_owner < 0) return {8'h00, 3'd0, 1'b0, m_rev};
        return {8'(1 << m_owner), 3'(m_owner), 1'b1, m_rev};
    endfunction

    function automatic logic [12:0] act_vec();
        return {gnt, gnt_idx, gnt_valid, revoked};
    endfunction

    function automatic void model_step();
        bit by_done, by_drop, by_time;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_rev = 1'b0;
        end else if (m_owner < 0) begin
            m_rev = 1'b0;
            for (int k = 0; k < 8; k++) begin
                int c;
                c = (m_ptr + k) % 8;
                if (m_owner < 0 && req[c]) begin
                    m_owner = c;
                    m_held  = 1;
                end
            end
        end else begin
            by_done = done;
            by_drop = !req[m_owner];
            by_time = (HOLD != 0) && (m_held == HOLD);
            if (by_done || by_drop || by_time) begin
                m_ptr   = (m_owner + 1) % 8;
                m_rev   = by_time && !by_done && !by_drop;
                m_owner = -1;
            end else begin
                m_held = m_held + 1;
                m_rev  = 1'b0;
            end
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 8'hFF; done = 1'b0;
        repeat (2) begin
            tick();
            n_checks++;
            if (act_vec() !== 13'h0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h required %h", act_vec(), 13'h0);
            end
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0 || gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL first_grant: got gnt=%h idx=%0d v=%b required gnt=01 idx=0 v=1",
                     gnt, gnt_idx, gnt_valid);
        end
    endtask

    task automatic test_rotation();
        int seen[$];
        int bound = 0;
        seen.push_back(int'(gnt_idx));
        while (seen.size() < 9 && bound < 40) begin
            done = gnt_valid;
            tick();
            bound++;
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL rotation_cycle: got %h required %h", act_vec(), exp_vec());
            end
            if (gnt_valid) seen.push_back(int'(gnt_idx));
        end
        done = 1'b0;
        n_checks++;
        if (seen.size() != 9) begin
            n_fail++;
            $display("FAIL rotation_count: got %0d grants required 9", seen.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                n_checks++;
                if (seen[i] != i % 8) begin
                    n_fail++;
                    $display("FAIL rotation_order[%0d]: got %0d required %0d", i, seen[i], i % 8);
                end
            end
        end
    endtask

    task automatic test_sparse();
        req = 8'h20; done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        n_checks++;
        if (gnt !== 8'h20) begin
            n_fail++;
            $display("FAIL sparse_setup: got gnt=%h required 20", gnt);
        end
        done = 1'b1;
        tick();
        done = 1'b0; req = 8'b0000_0100;
        tick();
        n_checks++;
        if (gnt !== 8'h04 || gnt_idx !== 3'd2 || act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL sparse_wrap: got gnt=%h idx=%0d required gnt=04 idx=2", gnt, gnt_idx);
        end
        done = 1'b1; req = 8'b1000_0100;
        tick();
        done = 1'b0;
        tick();
        n_checks++;
        if (gnt_idx !== 3'd7 || gnt !== 8'h80) begin
            n_fail++;
            $display("FAIL sparse_next: got gnt=%h idx=%0d required gnt=80 idx=7", gnt, gnt_idx);
        end
        done = 1'b1;
        tick();
        done = 1'b0; req = 8'h00;
        tick();
    endtask

    task automatic test_timeout();
        int n = 0;
        req = 8'h08;
        tick();
        while (gnt === 8'h08 && n < 20) begin
            n++;
            tick();
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL timeout_cycle: got %h required %h", act_vec(), exp_vec());
            end
        end
        n_checks++;
        if (n != HOLD) begin
            n_fail++;
            $display("FAIL timeout_length: got %0d cycles required %0d", n, HOLD);
        end
        n_checks++;
        if (revoked !== 1'b1 || gnt !== 8'h00) begin
            n_fail++;
            $display("FAIL timeout_revoked: got revoked=%b gnt=%h required revoked=1 gnt=00",
                     revoked, gnt);
        end
        tick();
        n_checks++;
        if (gnt !== 8'h08 || revoked !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_regrant: got gnt=%h revoked=%b required gnt=08 revoked=0",
                     gnt, revoked);
        end
        req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_simultaneous();
        req = 8'h08;
        tick();
        repeat (3) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        n_checks++;
        if (gnt !== 8'h00 || revoked !== 1'b0 || act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL done_with_timeout: got gnt=%h revoked=%b required gnt=00 revoked=0",
                     gnt, revoked);
        end
        tick();
        tick();
        req = 8'h00;
        tick();
        n_checks++;
        if (gnt !== 8'h00 || revoked !== 1'b0) begin
            n_fail++;
            $display("FAIL req_drop: got gnt=%h revoked=%b required gnt=00 revoked=0",
                     gnt, revoked);
        end
        tick();
    endtask

    task automatic test_reset_mid_grant();
        req = 8'h20;
        tick();
        n_checks++;
        if (gnt !== 8'h20) begin
            n_fail++;
            $display("FAIL midreset_setup: got gnt=%h required 20", gnt);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (act_vec() !== 13'h0) begin
            n_fail++;
            $display("FAIL midreset_clear: got %h required %h", act_vec(), 13'h0);
        end
        req = 8'h21;
        tick();
        n_checks++;
        if (gnt_idx !== 3'd0 || gnt !== 8'h01) begin
            n_fail++;
            $display("FAIL midreset_ptr: got gnt=%h idx=%0d required gnt=01 idx=0", gnt, gnt_idx);
        end
        req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            req  = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom & $urandom);
            done = ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 99) == 0);
            tick();
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_cycle[%0d]: got %h required %h", i, act_vec(), exp_vec());
            end
        end
        rst = 1'b0; req = 8'h00; done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 8'h00; done = 1'b0;
        test_reset();
        test_rotation();
        test_sparse();
        test_timeout();
        test_simultaneous();
        test_reset_mid_grant();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/oct_rr_arbiter.md
# oct_rr_arbiter

Eight-requester round-robin arbiter that shares one downstream resource among eight clients. It issues a registered one-hot grant plus its 3-bit binary index, the same octal-to-binary mapping the team's encoder uses. It holds the grant until the owner releases it or a hold timeout fires. It sits between the eight client request lines and the shared resource's select/enable input.

## Interface
- `HOLD_MAX`, default 16: maximum cycles one grant may be held; 0 disables the timeout; legal range 0–255.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 8: request lines; bit i = client i.
- `done` in 1: release strobe from the current owner; sampled only in GRANT.
- `gnt` out 8: registered one-hot grant; all-zero when idle.
- `gnt_idx` out 3: binary index of the set `gnt` bit; 3'd0 when `gnt` = 0.
- `gnt_valid` out 1: high exactly when `gnt` ≠ 0.
- `revoked` out 1: one-cycle pulse when a grant is ended by timeout.

## Operation
- The block has two states: IDLE and GRANT.
- Reset values:
  - state = IDLE
  - `gnt` = 8'h00
  - `gnt_idx` = 3'd0
  - `gnt_valid` = 0
  - `revoked` = 0
  - priority pointer `ptr` = 3'd0
  - hold counter = 0
- IDLE, `req` = 0: stay in IDLE; outputs stay zero.
- IDLE, `req` ≠ 0:
  - Select the first set bit scanning `ptr`, `ptr`+1, …, wrapping mod 8.
  - Register `gnt`, `gnt_idx` and `gnt_valid` = 1; clear the counter; go to GRANT.
- GRANT: the counter increments each cycle, saturating at 255. The grant is released when any of these holds:
  - (a) `done` = 1;
  - (b) `req[gnt_idx]` = 0;
  - (c) `HOLD_MAX` ≠ 0 and counter = `HOLD_MAX`−1.
- On release:
  - `ptr` ← `gnt_idx`+1 (mod 8, so 7 wraps to 0).
  - `gnt` ← 0, `gnt_valid` ← 0, `gnt_idx` ← 0.
  - State ← IDLE.
  - `revoked` ← 1 for one cycle only if (c) is true and neither (a) nor (b) is.
- Simultaneous (a) with (c) counts as a normal release: `revoked` = 0.
- Changes to other `req` bits during GRANT have no effect.
- `done` in IDLE is ignored.
- Reset asserted in GRANT drops the grant at that edge: all outputs return to their reset values and `ptr` returns to 0.

## Timing
- Grant latency: `req` sampled high at edge k → `gnt` visible after edge k (first full cycle k+1).
- With `HOLD_MAX` = N and the owner never releasing, `gnt` is high for exactly N cycles.
- The release cycle is followed by one mandatory idle cycle (`gnt` = 0) before the next grant. Minimum grant-to-grant spacing is therefore grant length + 1.
- `done` is honoured in the same edge it is sampled high. The owner sees `gnt` drop in the next cycle.
- `revoked` pulse coincides with the first cycle in which `gnt` = 0.
- `gnt_idx` and `gnt_valid` always change on the same edge as `gnt`; no combinational path from `req` to outputs.

## Structure
- A shared package holds:
  - `N_REQ` = 8 and `IDX_W` = 3;
  - the state enum (IDLE, GRANT);
  - the hold-counter width (8).
- One sub-module, `rr_pick8`, which is combinational:
  - Inputs: `req[7:0]` and `ptr[2:0]`.
  - Outputs: `pick_idx[2:0]` and `pick_any`.
  - Rotate-priority scan; `pick_onehot` is derived as 1 << `pick_idx`.
- The top level holds the FSM, `ptr`, counter and output registers.

## Test plan
- **Reset and idle:** assert `rst` 2 cycles with `req` = 8'hFF.
  - During reset: `gnt` = 0, `gnt_idx` = 0, `gnt_valid` = 0.
  - After release: first grant `gnt` = 8'h01, `gnt_idx` = 3'd0, one cycle after the first sampled edge.
- **Round-robin rotation:** `req` = 8'hFF, owner pulses `done` one cycle after each grant.
  - `gnt_idx` sequence is 0,1,2,…,7,0, with one zero-`gnt` cycle between grants; pointer wrap 7→0 checked.
- **Sparse requests:** `ptr` = 6, `req` = 8'b0000_0100 → `gnt` = 8'h04, `gnt_idx` = 2 (wrap past 7).
  - Then `req` = 8'b1000_0100 with release → next `gnt_idx` = 7.
- **Timeout:** `HOLD_MAX` = 4, `req` = 8'h08 held, `done` = 0.
  - `gnt` = 8'h08 for exactly 4 cycles, `revoked` = 1 on the following cycle.
  - Client 3 is re-granted after one idle cycle.
- **Simultaneous events:**
  - `done` = 1 in the same cycle the counter reaches `HOLD_MAX`−1 → release with `revoked` = 0.
  - Owner drops `req` mid-grant → release next edge, `revoked` = 0.
- **Reset mid-grant:** while `gnt` = 8'h20, assert `rst` for one cycle.
  - Next cycle `gnt` = 0 and `ptr` = 0.
  - With `req` = 8'h21 after reset, the next grant is `gnt_idx` = 0.
